// File: rtl/channel_sequencer.sv
// channel_sequencer
//   Steps a channel select through NCH channels of DW-bit opcodes. Each channel
//   is held for max(dwell,1) cycles. The sequence either runs once or wraps
//   continuously. Opcode patterns live in a shadow bank. A new pattern is taken
//   only while idle, in the one-cycle DONE state, or at the wrap boundary of a
//   looping run, so a pass in progress never sees a pattern change.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     begin a sequence (sampled in IDLE)
//   stop      abort a running sequence (sampled in RUN)
//   loop      1 = wrap after the last channel, 0 = one-shot
//   dwell     cycles per channel, 0 behaves as 1, sampled at channel entry
//   data      pattern to load, channel i at bits [i*DW +: DW]
//   load_req  level request to copy data into the shadow bank
//   load_ack  one-cycle pulse in the cycle after the shadow bank captured
//   sel       current channel index
//   opcode    shadow[sel] while valid, else 0
//   valid     sequence running
//   step      one-cycle pulse on the first cycle of each channel
//   busy      state is not IDLE
//   done      one-cycle pulse at one-shot completion
module channel_sequencer #(
    parameter int NCH = 4,
    parameter int DW  = 4,
    parameter int TW  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [TW-1:0]            dwell,
    input  logic [NCH*DW-1:0]        data,
    input  logic                     load_req,
    output logic                     load_ack,
    output logic [$clog2(NCH)-1:0]   sel,
    output logic [DW-1:0]            opcode,
    output logic                     valid,
    output logic                     step,
    output logic                     busy,
    output logic                     done
);

    localparam int SW = $clog2(NCH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SW-1:0]       r_sel;
    logic [TW-1:0]       r_cnt;
    logic [NCH*DW-1:0]   r_shadow;
    logic                r_step;
    logic                r_ack;

    logic [TW-1:0]       w_reload;
    logic                w_last;
    logic                w_cnt_zero;
    logic                w_boundary;
    logic                w_capture;
    logic                w_begin;

    // Counter holds the remaining cycles after the current one, so a dwell of
    // 0 or 1 both reload to 0 and the channel lasts exactly one cycle.
    assign w_reload   = (dwell == '0) ? '0 : dwell - TW'(1);
    assign w_last     = (r_sel == SW'(NCH - 1));
    assign w_cnt_zero = (r_cnt == '0);
    assign w_boundary = (r_state == S_RUN) && w_cnt_zero && w_last;
    assign w_begin    = (r_state == S_IDLE) && start && !stop;

    // Capture is blocked while load_ack is high so acks can never be
    // back-to-back; stop at the boundary suppresses capture and the request
    // is then served in IDLE on the following edge.
    assign w_capture = load_req && !r_ack &&
                       ((r_state == S_IDLE) ||
                        (r_state == S_DONE) ||
                        (w_boundary && loop && !stop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_next = S_IDLE;
                end else if (w_boundary && !loop) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_step   <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_ack  <= w_capture;
            if (w_capture) begin
                r_shadow <= data;
            end
            if (w_begin) begin
                r_sel  <= '0;
                r_cnt  <= w_reload;
                r_step <= 1'b1;
            end else if (r_state == S_RUN && !stop) begin
                if (!w_cnt_zero) begin
                    r_cnt <= r_cnt - TW'(1);
                end else if (!w_last) begin
                    r_sel  <= r_sel + SW'(1);
                    r_cnt  <= w_reload;
                    r_step <= 1'b1;
                end else if (loop) begin
                    r_sel  <= '0;
                    r_cnt  <= w_reload;
                    r_step <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        opcode = '0;
        if (r_state == S_RUN) begin
            opcode = r_shadow[int'(r_sel) * DW +: DW];
        end
    end

    assign sel      = r_sel;
    assign valid    = (r_state == S_RUN);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign step     = r_step;
    assign load_ack = r_ack;

endmodule

// File: tb/tb_channel_sequencer.sv
module tb_channel_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        lp;
    logic [3:0]  dwell;
    logic [15:0] data;
    logic        load_req;
    logic        load_ack;
    logic [1:0]  sel;
    logic [3:0]  opcode;
    logic        valid;
    logic        step;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Expected observation vector {valid,step,busy,done,load_ack,sel,opcode}
    // plus a mask (sel is a don't-care outside RUN).
    typedef struct packed {
        logic [10:0] e;
        logic [10:0] m;
    } exp_t;

    exp_t q[$];

    channel_sequencer #(.NCH(4), .DW(4), .TW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop     (lp),
        .dwell    (dwell),
        .data     (data),
        .load_req (load_req),
        .load_ack (load_ack),
        .sel      (sel),
        .opcode   (opcode),
        .valid    (valid),
        .step     (step),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [10:0] obs();
        return {valid, step, busy, done, load_ack, sel, opcode};
    endfunction

    function automatic exp_t mk(input logic v, input logic s, input logic b,
                                input logic d, input logic a, input logic [1:0] sl,
                                input logic sl_chk, input logic [3:0] op);
        exp_t x;
        x.e = {v, s, b, d, a, sl, op};
        x.m = sl_chk ? 11'h7FF : 11'h7CF;
        return x;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] pat, input int ch);
        return pat[ch*4 +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the one-shot dwell-1 sequence for a pattern: 4 channels, DONE, IDLE.
    task automatic push_oneshot(input logic [15:0] pat);
        for (int c = 0; c < 4; c++) begin
            q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'(c), 1'b1, nib(pat, c)));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0));
    endtask

    task automatic test_reset();
        exp_t x;
        logic [10:0] got;
        start = 0; stop = 0; lp = 0; dwell = 0; data = 0; load_req = 0;
        rst = 1'b1;
        tick();
        tick();
        x = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'h0);
        got = obs();
        checks++;
        if ((got & x.m) !== (x.e & x.m)) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", got, x.e);
        end
        rst = 1'b0;
        tick();
        got = obs();
        checks++;
        if ((got & x.m) !== (x.e & x.m)) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got, x.e);
        end
    endtask

    task automatic test_oneshot();
        exp_t x;
        logic [10:0] got;
        bit seen;
        data = 16'h0F5A;
        load_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (load_ack) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL idle_load_ack got=0 exp=1");
        end
        load_req = 1'b0;
        tick();
        checks++;
        if (load_ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_single got=%b exp=0", load_ack);
        end
        push_oneshot(16'h0F5A);
        start = 1'b1; dwell = 4'd1; lp = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = q.pop_front();
            got = obs();
            checks++;
            if ((got & x.m) !== (x.e & x.m)) begin
                errors++;
                $display("FAIL oneshot cyc %0d got=%b exp=%b", i, got, x.e);
            end
            tick();
        end
    endtask

    task automatic test_dwell3_loop();
        exp_t x;
        logic [10:0] got;
        for (int i = 0; i < 14; i++) begin
            q.push_back(mk(1'b1, (i % 3) == 0, 1'b1, 1'b0, 1'b0, 2'((i / 3) % 4), 1'b1,
                           nib(16'h0F5A, (i / 3) % 4)));
        end
        start = 1'b1; dwell = 4'd3; lp = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            x = q.pop_front();
            got = obs();
            checks++;
            if ((got & x.m) !== (x.e & x.m)) begin
                errors++;
                $display("FAIL dwell3 cyc %0d got=%b exp=%b", i, got, x.e);
            end
            if (i == 5) start = 1'b1;   // start while running must be ignored
            if (i == 6) start = 1'b0;
            tick();
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        x = q.pop_front();
        got = obs();
        checks++;
        if ((got & x.m) !== (x.e & x.m)) begin
            errors++;
            $display("FAIL dwell3_stop got=%b exp=%b", got, x.e);
        end
    endtask

    task automatic test_dwell0();
        exp_t x;
        logic [10:0] got;
        push_oneshot(16'h0F5A);
        start = 1'b1; dwell = 4'd0; lp = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = q.pop_front();
            got = obs();
            checks++;
            if ((got & x.m) !== (x.e & x.m)) begin
                errors++;
                $display("FAIL dwell0 cyc %0d got=%b exp=%b", i, got, x.e);
            end
            tick();
        end
    endtask

    task automatic test_load_during_run();
        exp_t x;
        logic [10:0] got;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                q.push_back(mk(1'b1, (i % 2) == 0, 1'b1, 1'b0, 1'b0, 2'(i / 2), 1'b1,
                               nib(16'h0F5A, i / 2)));
            end else begin
                q.push_back(mk(1'b1, (i % 2) == 0, 1'b1, 1'b0, i == 8, 2'((i - 8) / 2), 1'b1,
                               4'hF));
            end
        end
        start = 1'b1; dwell = 4'd2; lp = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            x = q.pop_front();
            got = obs();
            checks++;
            if ((got & x.m) !== (x.e & x.m)) begin
                errors++;
                $display("FAIL runload cyc %0d got=%b exp=%b", i, got, x.e);
            end
            if (i == 2) begin
                data = 16'hFFFF;
                load_req = 1'b1;
            end
            if (load_ack) load_req = 1'b0;
            tick();
        end
        checks++;
        if (load_req !== 1'b0) begin
            errors++;
            $display("FAIL runload_ack_seen got=0 exp=1");
            load_req = 1'b0;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_stop();
        exp_t x;
        logic [10:0] got;
        for (int c = 0; c < 3; c++) begin
            q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'(c), 1'b1, 4'hF));
        end
        for (int i = 0; i < 3; i++) begin
            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0));
        end
        start = 1'b1; dwell = 4'd1; lp = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = q.pop_front();
            got = obs();
            checks++;
            if ((got & x.m) !== (x.e & x.m)) begin
                errors++;
                $display("FAIL stop cyc %0d got=%b exp=%b", i, got, x.e);
            end
            start = 1'b0;
            stop = 1'b0;
            if (i == 2) stop = 1'b1;
            if (i == 3) begin
                start = 1'b1;
                stop = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t x;
        logic [10:0] got;
        start = 1'b1; dwell = 4'd2; lp = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        x = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'h0);
        got = obs();
        checks++;
        if ((got & x.m) !== (x.e & x.m)) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", got, x.e);
        end
        tick();
        rst = 1'b0;
        tick();
        push_oneshot(16'h0000);
        start = 1'b1; dwell = 4'd1; lp = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = q.pop_front();
            got = obs();
            checks++;
            if ((got & x.m) !== (x.e & x.m)) begin
                errors++;
                $display("FAIL post_reset cyc %0d got=%b exp=%b", i, got, x.e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_dwell3_loop();
        test_dwell0();
        test_load_during_run();
        test_stop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
